// File: rtl/matriz_mult_seq.sv
// Sequential signed matrix multiplier C = A x B, one MAC per clock, start/busy/done handshake.
// Build option: define SATURATE_EN to clamp out-of-range results instead of wrapping them.
module matriz_mult_seq #(
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned MAX_N  = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [3:0]                      dim,
  input  logic [MAX_N*MAX_N*ELEM_W-1:0]   A,
  input  logic [MAX_N*MAX_N*ELEM_W-1:0]   B,
  output logic [MAX_N*MAX_N*ELEM_W-1:0]   C,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow_flag
);

  localparam int unsigned ACC_W  = 2*ELEM_W + $clog2(MAX_N);
  localparam int unsigned IDX_W  = $clog2(MAX_N);
  localparam int unsigned FLAT_W = MAX_N*MAX_N*ELEM_W;

  localparam logic signed [ACC_W-1:0] E_MAX = ACC_W'(2**(ELEM_W-1) - 1);
  localparam logic signed [ACC_W-1:0] E_MIN = ~E_MAX;

  typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;

  state_t                    state, state_next;
  logic [FLAT_W-1:0]         a_q, b_q;
  logic [IDX_W-1:0]          nm1_q;
  logic [IDX_W-1:0]          i, j, k;
  logic signed [ACC_W-1:0]   acc;

  logic [IDX_W-1:0]          nm1_c;
  int unsigned               a_base_c, b_base_c, c_base_c;
  logic signed [ELEM_W-1:0]  a_e_c, b_e_c;
  logic signed [2*ELEM_W-1:0] prod_c;
  logic                      out_of_range_c;
  logic [ELEM_W-1:0]         result_c;

  // Clamp the requested dimension into 2..MAX_N, stored as N-1
  always_comb begin
    if (dim < 4'd2) begin
      nm1_c = IDX_W'(1);
    end else if (32'(dim) > MAX_N) begin
      nm1_c = IDX_W'(MAX_N - 1);
    end else begin
      nm1_c = IDX_W'(dim - 4'd1);
    end
  end

  // Operand fetch, product and result formatting for the current (i,j,k)
  always_comb begin
    a_base_c       = (32'(i) * MAX_N + 32'(k)) * ELEM_W;
    b_base_c       = (32'(k) * MAX_N + 32'(j)) * ELEM_W;
    c_base_c       = (32'(i) * MAX_N + 32'(j)) * ELEM_W;
    a_e_c          = a_q[a_base_c +: ELEM_W];
    b_e_c          = b_q[b_base_c +: ELEM_W];
    prod_c         = a_e_c * b_e_c;
    out_of_range_c = (acc > E_MAX) || (acc < E_MIN);
`ifdef SATURATE_EN
    if (acc > E_MAX) begin
      result_c = E_MAX[ELEM_W-1:0];
    end else if (acc < E_MIN) begin
      result_c = E_MIN[ELEM_W-1:0];
    end else begin
      result_c = acc[ELEM_W-1:0];
    end
`else
    result_c = acc[ELEM_W-1:0];
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (k == nm1_q) state_next = WRITE;
      WRITE:   state_next = (i == nm1_q && j == nm1_q) ? DONE : CALC;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q           <= '0;
      b_q           <= '0;
      nm1_q         <= '0;
      i             <= '0;
      j             <= '0;
      k             <= '0;
      acc           <= '0;
      C             <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overflow_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q           <= A;
            b_q           <= B;
            nm1_q         <= nm1_c;
            i             <= '0;
            j             <= '0;
            k             <= '0;
            acc           <= '0;
            C             <= '0;
            overflow_flag <= 1'b0;
            busy          <= 1'b1;
          end
        end
        CALC: begin
          acc <= acc + ACC_W'(prod_c);
          if (k != nm1_q) k <= k + IDX_W'(1);
        end
        WRITE: begin
          C[c_base_c +: ELEM_W] <= result_c;
          if (out_of_range_c) overflow_flag <= 1'b1;
          acc <= '0;
          k   <= '0;
          if (j == nm1_q) begin
            j <= '0;
            i <= i + IDX_W'(1);
          end else begin
            j <= j + IDX_W'(1);
          end
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matriz_mult_seq.sv
// Directed self-checking bench for matriz_mult_seq (ELEM_W=8, MAX_N=5).
// Expected C values follow the SATURATE_EN build setting.
module tb_matriz_mult_seq;

  localparam int unsigned ELEM_W = 8;
  localparam int unsigned MAX_N  = 5;
  localparam int unsigned FLAT_W = MAX_N*MAX_N*ELEM_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [3:0]        dim;
  logic [FLAT_W-1:0] a, b, c;
  logic              busy, done, overflow_flag;

  int compared   = 0;
  int mismatched = 0;

  logic [FLAT_W-1:0] b1, exp_b1, ident;

  always #5 clk = ~clk;

  matriz_mult_seq #(.ELEM_W(ELEM_W), .MAX_N(MAX_N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dim(dim),
    .A(a), .B(b), .C(c),
    .busy(busy), .done(done), .overflow_flag(overflow_flag)
  );

  function automatic logic [FLAT_W-1:0] set_el(input logic [FLAT_W-1:0] f, input int i,
                                               input int j, input logic [ELEM_W-1:0] v);
    logic [FLAT_W-1:0] r;
    r = f;
    r[(i*MAX_N+j)*ELEM_W +: ELEM_W] = v;
    return r;
  endfunction

  function automatic logic [FLAT_W-1:0] fill(input logic [ELEM_W-1:0] v, input int n);
    logic [FLAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        r = set_el(r, i, j, v);
    return r;
  endfunction

  task automatic launch(input logic [3:0] d, input logic [FLAT_W-1:0] av,
                        input logic [FLAT_W-1:0] bv);
    @(negedge clk);
    dim   = d;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dim = 4'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({busy, done, overflow_flag} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_flags: got %b expected 000", {busy, done, overflow_flag});
    end
    compared++;
    if (c !== '0) begin
      mismatched++;
      $display("FAIL reset_c: got %h expected 0", c);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_identity_n2(input logic [3:0] d, input string tag);
    int cyc;
    launch(d, ident, b1);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_busy_start: got %b expected 1", tag, busy);
    end
    wait_done(cyc);
    compared++;
    if (cyc !== 13) begin
      mismatched++;
      $display("FAIL %s_latency: got %0d expected 13", tag, cyc);
    end
    compared++;
    if (c !== exp_b1) begin
      mismatched++;
      $display("FAIL %s_c: got %h expected %h", tag, c, exp_b1);
    end
    compared++;
    if ({busy, overflow_flag} !== 2'b00) begin
      mismatched++;
      $display("FAIL %s_busy_ovf: got %b expected 00", tag, {busy, overflow_flag});
    end
    @(posedge clk);
    #1;
    compared++;
    if (done !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_done_pulse: got %b expected 0", tag, done);
    end
  endtask

  task automatic test_overflow_n3();
    int cyc;
    logic [ELEM_W-1:0] r;
`ifdef SATURATE_EN
    r = 8'h7F;
`else
    r = 8'h03;
`endif
    launch(4'd3, fill(8'd127, 5), fill(8'd127, 5));
    wait_done(cyc);
    compared++;
    if (cyc !== 37) begin
      mismatched++;
      $display("FAIL n3_latency: got %0d expected 37", cyc);
    end
    compared++;
    if (c !== fill(r, 3)) begin
      mismatched++;
      $display("FAIL n3_c: got %h expected %h", c, fill(r, 3));
    end
    compared++;
    if (overflow_flag !== 1'b1) begin
      mismatched++;
      $display("FAIL n3_ovf: got %b expected 1", overflow_flag);
    end
  endtask

  task automatic test_dim_high_n5();
    int cyc;
    logic [ELEM_W-1:0] r;
`ifdef SATURATE_EN
    r = 8'h7F;
`else
    r = 8'h00;
`endif
    launch(4'd9, fill(8'h80, 5), fill(8'h80, 5));
    wait_done(cyc);
    compared++;
    if (cyc !== 151) begin
      mismatched++;
      $display("FAIL n5_latency: got %0d expected 151", cyc);
    end
    compared++;
    if (c !== fill(r, 5)) begin
      mismatched++;
      $display("FAIL n5_c: got %h expected %h", c, fill(r, 5));
    end
    compared++;
    if (overflow_flag !== 1'b1) begin
      mismatched++;
      $display("FAIL n5_ovf: got %b expected 1", overflow_flag);
    end
  endtask

  task automatic test_start_ignored();
    int cyc, extra;
    logic [FLAT_W-1:0] a1, bm, exp;
    a1  = set_el(set_el(set_el(set_el('0, 0, 0, 8'd1), 0, 1, 8'd2), 1, 0, 8'd3), 1, 1, 8'd4);
    bm  = set_el(set_el(set_el(set_el('0, 0, 0, 8'd5), 0, 1, 8'd6), 1, 0, 8'd7), 1, 1, 8'd8);
    exp = set_el(set_el(set_el(set_el('0, 0, 0, 8'd19), 0, 1, 8'd22), 1, 0, 8'd43), 1, 1, 8'd50);
    launch(4'd2, a1, bm);
    repeat (4) @(posedge clk);
    #1;
    a = '0; b = fill(8'd1, 5); dim = 4'd5; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc);
    compared++;
    if (cyc !== 7) begin
      mismatched++;
      $display("FAIL midrun_latency: got %0d expected 7", cyc);
    end
    compared++;
    if (c !== exp) begin
      mismatched++;
      $display("FAIL midrun_c: got %h expected %h", c, exp);
    end
    compared++;
    if (overflow_flag !== 1'b0) begin
      mismatched++;
      $display("FAIL midrun_ovf: got %b expected 0", overflow_flag);
    end
    extra = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    compared++;
    if (extra !== 0) begin
      mismatched++;
      $display("FAIL midrun_second_op: got %0d active cycles expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    launch(4'd2, ident, b1);
    wait_done(cyc);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    compared++;
    if ({busy, done} !== 2'b10) begin
      mismatched++;
      $display("FAIL b2b_accept: got %b expected 10", {busy, done});
    end
    wait_done(cyc);
    compared++;
    if (cyc !== 13) begin
      mismatched++;
      $display("FAIL b2b_latency: got %0d expected 13", cyc);
    end
    compared++;
    if (c !== exp_b1) begin
      mismatched++;
      $display("FAIL b2b_c: got %h expected %h", c, exp_b1);
    end
  endtask

  task automatic test_reset_mid();
    logic [FLAT_W-1:0] part;
    part = set_el(fill(8'd5, 0), 1, 0, 8'd5);
    for (int j = 0; j < 5; j++) part = set_el(part, 0, j, 8'd5);
    launch(4'd5, fill(8'd1, 5), fill(8'd1, 5));
    repeat (40) @(posedge clk);
    #1;
    compared++;
    if (c !== part) begin
      mismatched++;
      $display("FAIL rstmid_partial_c: got %h expected %h", c, part);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if ({c != '0, busy, done} !== 3'b000) begin
      mismatched++;
      $display("FAIL rstmid_clear: got c_nonzero/busy/done %b expected 000", {c != '0, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_identity_n2(4'd2, "after_rst");
  endtask

  initial begin
    b1 = set_el(set_el(set_el(set_el('0, 0, 0, 8'd5), 0, 1, 8'hFD), 1, 0, 8'd7), 1, 1, 8'd2);
    exp_b1 = b1;
    b1 = set_el(b1, 4, 4, 8'h11);
    b1 = set_el(b1, 2, 3, 8'h22);
    ident = set_el(set_el('0, 0, 0, 8'd1), 1, 1, 8'd1);
    ident = set_el(ident, 3, 3, 8'd9);

    test_reset();
    test_identity_n2(4'd2, "n2_ident");
    test_overflow_n3();
    test_identity_n2(4'd0, "dim0");
    test_dim_high_n5();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
